// File: rtl/multiplier_32b_rr_sched.sv
// Round-robin front end for one shared, pipelined 32x32 multiplier.
// A {valid, id} tag rides alongside the external multiplier so each product returns to its requester.
module multiplier_32b_rr_sched #(
   parameter int NREQ    = 4,
   parameter int PPCYCLE = 1,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                 iClk,
   input  logic                 iRstN,
   input  logic [NREQ-1:0]      iReqValid,
   input  logic [NREQ*32-1:0]   iReqData0,
   input  logic [NREQ*32-1:0]   iReqData1,
   output logic [NREQ-1:0]      oReqReady,
   input  logic                 iFlush,
   output logic                 oMulEn,
   output logic                 oMulClr,
   output logic [31:0]          oMulData0,
   output logic [31:0]          oMulData1,
   input  logic [63:0]          iMulData,
   output logic                 oRspValid,
   output logic [IDW-1:0]       oRspId,
   output logic [63:0]          oRspData
);

   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [PPCYCLE-1:0] tag_vld_q, tag_vld_d;
   logic [IDW-1:0]     tag_id_q [PPCYCLE];
   logic [IDW-1:0]     tag_id_d [PPCYCLE];
   logic               grant;
   logic [IDW-1:0]     gnt_id;
   logic [IDW-1:0]     scan_idx;

   // Scan starts one above the last grant; NREQ is a power of two so the add wraps on its own.
   always_comb begin
      grant    = 1'b0;
      gnt_id   = '0;
      scan_idx = '0;
      for (int off = 1; off <= NREQ; off++) begin
         scan_idx = ptr_q + IDW'(off);
         if (!grant && iReqValid[scan_idx]) begin
            grant  = 1'b1;
            gnt_id = scan_idx;
         end
      end
      if (!iRstN || iFlush) begin
         grant  = 1'b0;
         gnt_id = '0;
      end
   end

   always_comb begin
      oReqReady = grant ? (NREQ'(1) << gnt_id) : '0;
      oMulData0 = grant ? iReqData0[32*gnt_id +: 32] : 32'd0;
      oMulData1 = grant ? iReqData1[32*gnt_id +: 32] : 32'd0;
      oMulEn    = iRstN && (grant || (|tag_vld_q));
      oMulClr   = !iRstN || iFlush;
      oRspValid = iRstN && tag_vld_q[PPCYCLE-1];
      oRspId    = oRspValid ? tag_id_q[PPCYCLE-1] : '0;
      oRspData  = oRspValid ? iMulData : 64'd0;
   end

   // Tags only move when the multiplier moves, keeping them aligned with iMulData.
   always_comb begin
      ptr_d     = grant ? gnt_id : ptr_q;
      tag_vld_d = tag_vld_q;
      tag_id_d  = tag_id_q;
      if (oMulEn) begin
         tag_vld_d[0] = grant;
         tag_id_d[0]  = gnt_id;
         for (int s = 1; s < PPCYCLE; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
         end
      end
      if (iFlush) tag_vld_d = '0;
   end

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         ptr_q     <= IDW'(NREQ-1);
         tag_vld_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         tag_vld_q <= tag_vld_d;
      end
   end

   always_ff @(posedge iClk) begin
      tag_id_q <= tag_id_d;
   end

endmodule
